hls_deadlock_monitor_param: RTL and testbench
=============================================

# hls_deadlock_monitor_param

Parametrised deadlock monitor for HLS-generated dataflow regions in the resonator DDC control path. It watches N_AXIS AXI-Stream block signals and N_INST sub-instance block/idle pairs. Its `block` output is a registered OR of those inputs, kept for drop-in use with existing monitor chains. On top of that it measures consecutive stall length and latches a sticky `deadlock` flag, with a snapshot of the offending sources, once a stall persists for THRESHOLD cycles.

## Interface
- N_AXIS, 2, number of AXI-Stream block inputs (>=1)
- N_INST, 1, number of sub-instance idle/block pairs (>=1)
- CNT_W, 16, stall counter width
- THRESHOLD, 1024, consecutive blocked cycles before `deadlock` latches; 1 <= THRESHOLD <= 2^CNT_W-1
- clock  in  1  all logic on rising edge
- reset  in  1  synchronous, active-high
- axis_block_sigs  in  N_AXIS  per-stream blocked indication
- inst_idle_sigs  in  N_INST  per-instance idle
- inst_block_sigs  in  N_INST  per-instance blocked
- clear  in  1  single-cycle pulse; re-arms detector
- block  out  1  registered any-block, 1-cycle latency
- deadlock  out  1  sticky deadlock flag
- block_src  out  N_AXIS+N_INST  snapshot {inst_active_block, axis_block_sigs} at detection
- stall_cnt  out  CNT_W  current consecutive blocked cycle count, saturating

## Operation
- inst_active_block = inst_block_sigs & ~inst_idle_sigs; idle instances never count as blocked.
- any_block = |axis_block_sigs | |inst_active_block (combinational, internal).
- block <= any_block every cycle.
- stall_cnt: any_block=1 -> stall_cnt+1, saturating at 2^CNT_W-1; any_block=0 -> 0. Counts in all FSM states.
- FSM states:
  - IDLE: stall_cnt=0, no block.
  - COUNT: block in progress, not yet latched.
  - LATCHED: deadlock=1.
- Transitions:
  - IDLE->COUNT when any_block.
  - COUNT->IDLE when !any_block.
  - COUNT or IDLE -> LATCHED when any_block && stall_cnt==THRESHOLD-1, i.e. on the THRESHOLD-th consecutive blocked cycle.
  - LATCHED->IDLE only on clear.
- On entry to LATCHED: deadlock <= 1; block_src <= {inst_active_block, axis_block_sigs} sampled that cycle.
- While LATCHED, further blocks neither recapture nor modify block_src; release of the block does not clear deadlock.
- clear:
  - Next cycle: deadlock=0, block_src=0, stall_cnt=0, state IDLE.
  - Clear has priority over a detection in the same cycle; that detection is discarded and counting restarts from 0.
  - Clear does not affect `block`.
- THRESHOLD=1: deadlock latches on the same edge that first registers block=1.

## Timing
- Reset values: block=0, deadlock=0, block_src=0, stall_cnt=0, state IDLE.
- Reset mid-stall or while LATCHED returns all outputs to 0 on the next edge.
- Counting restarts only on inputs sampled after reset deasserts.
- block latency: 1 cycle from input.
- deadlock latency: asserted after edge k+THRESHOLD-1, where edge k is the first edge sampling any_block=1 with continuous blocking. Worst case THRESHOLD cycles from stall start.
- A single-cycle drop in any_block resets stall_cnt; the stall must again last THRESHOLD consecutive cycles.
- All outputs registered; no combinational input-to-output paths.

## Test plan
Config for tests 1–5: N_AXIS=2, N_INST=1, CNT_W=8, THRESHOLD=4. block_src bit order is {inst0, axis1, axis0}.
1. Reset held 3 cycles with all inputs driven high -> every output 0 throughout. After release with inputs still high -> block=1 one cycle later; stall_cnt=1.
2. axis_block_sigs=2'b10 for 3 cycles then 0 -> block high 3 cycles delayed by 1; stall_cnt 1,2,3,0; deadlock never asserts.
3. axis_block_sigs=2'b01 for 6 cycles -> deadlock rises after 4th edge, block_src=3'b001. After input drops, deadlock stays 1 and block_src unchanged while axis_block_sigs=2'b10 is later pulsed.
4. inst_block=1, inst_idle=1 for 10 cycles -> block=0, stall_cnt=0. Then inst_idle=0 for 4 cycles -> deadlock=1, block_src=3'b100.
5. Clear pulsed on the 4th blocked cycle -> deadlock remains 0 and stall_cnt=0 next cycle. Continued blocking -> deadlock 4 cycles later. A second clear while blocked -> deadlock=0, block_src=0, redetect after 4 more cycles.
6. CNT_W=3, THRESHOLD=7, block held 20 cycles -> deadlock after 7th edge; stall_cnt saturates and holds at 7, no wrap to 0.

Source files
------------

// File: rtl/hls_deadlock_monitor_param.sv
// Deadlock monitor for HLS dataflow regions: registered any-block OR, saturating
// consecutive-stall counter, and a sticky deadlock flag with a snapshot of the blocking sources.
module hls_deadlock_monitor_param #(
  parameter int unsigned N_AXIS    = 2,
  parameter int unsigned N_INST    = 1,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned THRESHOLD = 1024
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_AXIS-1:0]        axis_block_sigs,
  input  logic [N_INST-1:0]        inst_idle_sigs,
  input  logic [N_INST-1:0]        inst_block_sigs,
  input  logic                     clear,
  output logic                     block,
  output logic                     deadlock,
  output logic [N_AXIS+N_INST-1:0] block_src,
  output logic [CNT_W-1:0]         stall_cnt
);

  // state     | meaning
  // S_IDLE    | no stall in progress, stall_cnt = 0
  // S_COUNT   | stall in progress, deadlock not yet latched
  // S_LATCHED | deadlock latched; held until clear or reset
  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_LATCHED} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THR_M1  = CNT_W'(THRESHOLD - 1);

  state_t             state;
  logic [N_INST-1:0]  inst_active_block;
  logic               any_block;
  logic               detect;

  // An idle instance is never considered blocked, whatever its block line says.
  assign inst_active_block = inst_block_sigs & ~inst_idle_sigs;
  assign any_block         = (|axis_block_sigs) | (|inst_active_block);
  assign detect            = any_block && (stall_cnt == THR_M1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      block     <= 1'b0;
      deadlock  <= 1'b0;
      block_src <= '0;
      stall_cnt <= '0;
    end else begin
      block <= any_block;
      if (clear) begin
        // Clear wins over a same-cycle detection; counting restarts from zero.
        state     <= S_IDLE;
        deadlock  <= 1'b0;
        block_src <= '0;
        stall_cnt <= '0;
      end else begin
        if (!any_block)
          stall_cnt <= '0;
        else if (stall_cnt != CNT_MAX)
          stall_cnt <= stall_cnt + CNT_W'(1);

        case (state)
          S_IDLE, S_COUNT: begin
            if (detect) begin
              state     <= S_LATCHED;
              deadlock  <= 1'b1;
              block_src <= {inst_active_block, axis_block_sigs};
            end else if (any_block) begin
              state <= S_COUNT;
            end else begin
              state <= S_IDLE;
            end
          end
          S_LATCHED: state <= S_LATCHED;
          default:   state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hls_deadlock_monitor_param.sv
// Bench for hls_deadlock_monitor_param: per-cycle scoreboard from a behavioural model,
// plus directed checks of the key points of each scenario and a saturation config.
module tb_hls_deadlock_monitor_param;

  localparam int THR  = 4;
  localparam int MAXC = 255;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] axis_block_sigs;
  logic [0:0] inst_idle_sigs, inst_block_sigs;
  logic       clear;
  logic       block, deadlock;
  logic [2:0] block_src;
  logic [7:0] stall_cnt;

  logic [1:0] b_axis;
  logic [0:0] b_idle, b_blk;
  logic       b_clear;
  logic       b_block, b_deadlock;
  logic [2:0] b_src;
  logic [2:0] b_cnt;

  always #5 clock = ~clock;

  hls_deadlock_monitor_param #(.N_AXIS(2), .N_INST(1), .CNT_W(8), .THRESHOLD(THR)) dut (
    .clock(clock), .reset(reset), .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs), .clear(clear),
    .block(block), .deadlock(deadlock), .block_src(block_src), .stall_cnt(stall_cnt));

  hls_deadlock_monitor_param #(.N_AXIS(2), .N_INST(1), .CNT_W(3), .THRESHOLD(7)) dut_sat (
    .clock(clock), .reset(reset), .axis_block_sigs(b_axis),
    .inst_idle_sigs(b_idle), .inst_block_sigs(b_blk), .clear(b_clear),
    .block(b_block), .deadlock(b_deadlock), .block_src(b_src), .stall_cnt(b_cnt));

  typedef struct packed {
    logic       blk;
    logic       dl;
    logic [2:0] src;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // behavioural reference state
  logic       m_blk = 1'b0, m_dl = 1'b0;
  logic [2:0] m_src = '0;
  int         m_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, predict the post-edge outputs, then compare after the edge.
  task automatic step(input logic [1:0] ax, input logic idl, input logic blk,
                      input logic clr, input logic rst);
    logic act, any;
    exp_t e, g;
    axis_block_sigs = ax;
    inst_idle_sigs  = idl;
    inst_block_sigs = blk;
    clear           = clr;
    reset           = rst;
    act = blk & ~idl;
    any = (|ax) | act;
    if (rst) begin
      m_blk = 0; m_dl = 0; m_src = '0; m_cnt = 0;
    end else begin
      m_blk = any;
      if (clr) begin
        m_dl = 0; m_src = '0; m_cnt = 0;
      end else begin
        if (!m_dl && any && m_cnt == THR - 1) begin
          m_dl  = 1;
          m_src = {act, ax};
        end
        m_cnt = any ? ((m_cnt < MAXC) ? m_cnt + 1 : MAXC) : 0;
      end
    end
    e.blk = m_blk; e.dl = m_dl; e.src = m_src; e.cnt = 8'(m_cnt);
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    g = exp_q.pop_front();
    check("sb_block",     block,     g.blk);
    check("sb_deadlock",  deadlock,  g.dl);
    check("sb_block_src", block_src, g.src);
    check("sb_stall_cnt", stall_cnt, g.cnt);
  endtask

  initial begin
    b_axis = '0; b_idle = '0; b_blk = '0; b_clear = 1'b0;

    // 1: reset with all inputs high
    for (int i = 0; i < 3; i++) begin
      step(2'b11, 1'b1, 1'b1, 1'b0, 1'b1);
      check("t1_rst_block", block, 0);
      check("t1_rst_dl", deadlock, 0);
      check("t1_rst_cnt", stall_cnt, 0);
      check("t1_rst_src", block_src, 0);
    end
    step(2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t1_post_block", block, 1);
    check("t1_post_cnt", stall_cnt, 1);
    step(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);

    // 2: short stall, no detection
    for (int i = 1; i <= 3; i++) begin
      step(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
      check("t2_block", block, 1);
      check("t2_cnt", stall_cnt, i);
      check("t2_dl", deadlock, 0);
    end
    step(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t2_drop_block", block, 0);
    check("t2_drop_cnt", stall_cnt, 0);

    // 3: detection and sticky snapshot
    for (int i = 1; i <= 6; i++) begin
      step(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
      check("t3_dl", deadlock, (i >= 4) ? 1 : 0);
    end
    check("t3_src", block_src, 3'b001);
    step(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    step(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t3_sticky_dl", deadlock, 1);
    check("t3_sticky_src", block_src, 3'b001);
    step(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t3_clr_dl", deadlock, 0);

    // 4: idle instance masks its block
    for (int i = 0; i < 10; i++) begin
      step(2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
      check("t4_idle_block", block, 0);
      check("t4_idle_cnt", stall_cnt, 0);
    end
    for (int i = 1; i <= 4; i++) step(2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t4_dl", deadlock, 1);
    check("t4_src", block_src, 3'b100);
    step(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);

    // 5: clear beats same-cycle detection, then clear while latched and blocked
    for (int i = 0; i < 3; i++) step(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    step(2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t5_clr_dl", deadlock, 0);
    check("t5_clr_cnt", stall_cnt, 0);
    check("t5_clr_block", block, 1);
    for (int i = 1; i <= 4; i++) begin
      step(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
      check("t5_redet", deadlock, (i == 4) ? 1 : 0);
    end
    step(2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t5_clr2_dl", deadlock, 0);
    check("t5_clr2_src", block_src, 0);
    for (int i = 1; i <= 4; i++) begin
      step(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
      check("t5_redet2", deadlock, (i == 4) ? 1 : 0);
    end
    check("t5_src2", block_src, 3'b001);

    // reset while latched and stalled
    step(2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_latched_dl", deadlock, 0);
    check("rst_latched_block", block, 0);
    step(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_restart_cnt", stall_cnt, 1);
    step(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // 6: CNT_W=3, THRESHOLD=7 saturation
    b_axis = 2'b01;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock);
      #1;
      check("t6_cnt", b_cnt, (i < 7) ? i : 7);
      check("t6_dl", b_deadlock, (i >= 7) ? 1 : 0);
    end
    check("t6_src", b_src, 3'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
